uart6551_dmac: RTL and testbench

Byte-oriented DMA sequencer for the uart6551 serial port. Services the UART's receive and transmit DMA requests by running Wishbone master cycles: each received byte goes from the UART data register into a memory buffer, and each transmit byte goes from a memory buffer into the UART data register. It sits between the system bus and one uart6551 instance. Software programs it through a small Wishbone slave register file.

---
 rtl/uart6551_dmac_pkg.sv | 40 ++++
 rtl/uart6551_dmac_regs.sv | 128 ++++++++++++
 rtl/uart6551_dmac.sv | 176 +++++++++++++++++
 tb/tb_uart6551_dmac.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart6551_dmac_pkg.sv
// uart6551_dmac_pkg: shared types and constants for the uart6551 DMA sequencer.
// Holds the sequencer state enum, slave register indices and CTRL/STAT bit positions.
// Also defines the per-channel pointer struct and the byte-lane select helper.
package uart6551_dmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_RD,
    ST_RX_WR,
    ST_TX_RD,
    ST_TX_WR,
    ST_GAP
  } state_t;

  localparam logic [2:0] REG_TXADR = 3'd0;
  localparam logic [2:0] REG_TXCNT = 3'd1;
  localparam logic [2:0] REG_RXADR = 3'd2;
  localparam logic [2:0] REG_RXCNT = 3'd3;
  localparam logic [2:0] REG_CTRL  = 3'd4;

  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_RX_EN   = 1;
  localparam int CTRL_TX_IE   = 2;
  localparam int CTRL_RX_IE   = 3;
  localparam int CTRL_TX_DONE = 8;
  localparam int CTRL_RX_DONE = 9;
  localparam int CTRL_BUS_ERR = 10;

  // Buffer pointer of one channel: next byte address and bytes remaining.
  typedef struct packed {
    logic [31:0] adr;
    logic [15:0] cnt;
  } chan_t;

  // One-hot Wishbone byte-lane select for a byte address.
  function automatic logic [3:0] lane_sel(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

endpackage

// File: rtl/uart6551_dmac_regs.sv
// uart6551_dmac_regs: Wishbone slave register file (TXADR/TXCNT/RXADR/RXCNT/CTRL) with W1C status.
// Latency: ack one cycle after request, read data valid with ack, writes commit on the ack edge.
// Backpressure: none; every request is acked after one cycle, a slave write overrides same-cycle sequencer updates.
// Ports: req/we/adr/wdat/ack/rdat slave side; tx_step/rx_step/err_set sequencer updates;
//        tx/rx pointers, tx_en/rx_en to the sequencer; irq registered interrupt.
module uart6551_dmac_regs
  import uart6551_dmac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  adr,
  input  logic [31:0] wdat,
  output logic        ack,
  output logic [31:0] rdat,
  input  logic        tx_step,
  input  logic        rx_step,
  input  logic        err_set,
  output chan_t       tx,
  output chan_t       rx,
  output logic        tx_en,
  output logic        rx_en,
  output logic        irq
);

  logic        tx_ie, rx_ie, tx_done, rx_done, bus_err;
  logic        wr;
  logic [31:0] rd_mux;

  assign wr = req & ack & we;

  always_comb begin
    rd_mux = '0;
    case (adr)
      REG_TXADR: rd_mux = tx.adr;
      REG_TXCNT: rd_mux = {16'h0, tx.cnt};
      REG_RXADR: rd_mux = rx.adr;
      REG_RXCNT: rd_mux = {16'h0, rx.cnt};
      REG_CTRL: begin
        rd_mux[CTRL_TX_EN]   = tx_en;
        rd_mux[CTRL_RX_EN]   = rx_en;
        rd_mux[CTRL_TX_IE]   = tx_ie;
        rd_mux[CTRL_RX_IE]   = rx_ie;
        rd_mux[CTRL_TX_DONE] = tx_done;
        rd_mux[CTRL_RX_DONE] = rx_done;
        rd_mux[CTRL_BUS_ERR] = bus_err;
      end
      default: rd_mux = '0;
    endcase
  end

  // Later assignments in this block take priority: sequencer updates,
  // then empty-channel auto-complete, then bus error, then the slave write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack     <= 1'b0;
      rdat    <= '0;
      irq     <= 1'b0;
      tx      <= '0;
      rx      <= '0;
      tx_en   <= 1'b0;
      rx_en   <= 1'b0;
      tx_ie   <= 1'b0;
      rx_ie   <= 1'b0;
      tx_done <= 1'b0;
      rx_done <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      ack  <= req & ~ack;
      rdat <= (req & ~ack) ? rd_mux : '0;
      irq  <= (tx_done & tx_ie) | (rx_done & rx_ie) | bus_err;

      if (tx_step) begin
        tx.adr <= tx.adr + 32'd1;
        if (tx.cnt != 16'd0) tx.cnt <= tx.cnt - 16'd1;
        if (tx.cnt <= 16'd1) begin
          tx_en   <= 1'b0;
          tx_done <= 1'b1;
        end
      end
      if (rx_step) begin
        rx.adr <= rx.adr + 32'd1;
        if (rx.cnt != 16'd0) rx.cnt <= rx.cnt - 16'd1;
        if (rx.cnt <= 16'd1) begin
          rx_en   <= 1'b0;
          rx_done <= 1'b1;
        end
      end

      // An enabled channel with nothing to move completes without a bus cycle.
      if (tx_en && tx.cnt == 16'd0) begin
        tx_en   <= 1'b0;
        tx_done <= 1'b1;
      end
      if (rx_en && rx.cnt == 16'd0) begin
        rx_en   <= 1'b0;
        rx_done <= 1'b1;
      end

      if (err_set) begin
        bus_err <= 1'b1;
        tx_en   <= 1'b0;
        rx_en   <= 1'b0;
      end

      if (wr) begin
        case (adr)
          REG_TXADR: tx.adr <= wdat;
          REG_TXCNT: tx.cnt <= wdat[15:0];
          REG_RXADR: rx.adr <= wdat;
          REG_RXCNT: rx.cnt <= wdat[15:0];
          REG_CTRL: begin
            tx_en <= wdat[CTRL_TX_EN];
            rx_en <= wdat[CTRL_RX_EN];
            tx_ie <= wdat[CTRL_TX_IE];
            rx_ie <= wdat[CTRL_RX_IE];
            if (wdat[CTRL_TX_DONE]) tx_done <= 1'b0;
            if (wdat[CTRL_RX_DONE]) rx_done <= 1'b0;
            if (wdat[CTRL_BUS_ERR]) bus_err <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart6551_dmac.sv
// uart6551_dmac: byte DMA sequencer moving UART RX bytes to memory and memory bytes to UART TX.
// Latency: cyc/stb rise the cycle after a channel is pending; one byte = read, GAP, write in one tenure.
// Backpressure: m_stb_o held until m_ack_i/m_err_i; the UART DRQ is ignored for pGuard cycles after access.
// Ports: clk_i/rst_i; cs_i/cyc_i/stb_i/we_i/adr_i/dat_i/dat_o/ack_o slave; m_* Wishbone master;
//        rxDRQ_i/txDRQ_i level requests from the UART; irq_o registered interrupt.
module uart6551_dmac
  import uart6551_dmac_pkg::*;
#(
  parameter logic [31:0] pUartBase = 32'hFFDC0A00,
  parameter int          pGuard    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  input  logic        we_i,
  input  logic [4:2]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic [31:0] m_dat_i,
  input  logic        rxDRQ_i,
  input  logic        txDRQ_i,
  output logic        irq_o
);

  localparam logic [3:0] GUARD = 4'(pGuard);

  state_t      state, nxt;
  chan_t       tx, rx;
  logic        tx_en, rx_en;
  logic        tx_step, rx_step, err_set;
  logic        rx_pend, tx_pend, rx_win, tx_win;
  logic        last_rx;   // 1: RX was the channel served most recently
  logic        gap_tx;    // GAP leads into TX_WR rather than RX_WR
  logic        done_ph;   // current bus phase terminated without error
  logic [31:0] cur_adr;
  logic [7:0]  byte_q;
  logic [3:0]  rx_guard, tx_guard;

  uart6551_dmac_regs u_regs (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (cs_i & cyc_i & stb_i),
    .we      (we_i),
    .adr     (adr_i),
    .wdat    (dat_i),
    .ack     (ack_o),
    .rdat    (dat_o),
    .tx_step (tx_step),
    .rx_step (rx_step),
    .err_set (err_set),
    .tx      (tx),
    .rx      (rx),
    .tx_en   (tx_en),
    .rx_en   (rx_en),
    .irq     (irq_o)
  );

  assign rx_pend = rx_en && (rx.cnt != 16'd0) && rxDRQ_i && (rx_guard == 4'd0);
  assign tx_pend = tx_en && (tx.cnt != 16'd0) && txDRQ_i && (tx_guard == 4'd0);
  // On a tie the channel not served last goes first.
  assign rx_win  = rx_pend && (!tx_pend || !last_rx);
  assign tx_win  = tx_pend && !rx_win;
  assign done_ph = m_ack_i && !m_err_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt     = state;
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_sel_o = 4'b0000;
    m_adr_o = '0;
    m_dat_o = '0;
    tx_step = 1'b0;
    rx_step = 1'b0;
    err_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_win)      nxt = ST_RX_RD;
        else if (tx_win) nxt = ST_TX_RD;
      end
      ST_RX_RD: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_sel_o = 4'b0001;
        m_adr_o = pUartBase;
        if (m_err_i)      begin err_set = 1'b1; nxt = ST_IDLE; end
        else if (m_ack_i) nxt = ST_GAP;
      end
      ST_RX_WR: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_sel_o = lane_sel(cur_adr[1:0]);
        m_adr_o = cur_adr;
        m_dat_o = {4{byte_q}};
        if (m_err_i)      begin err_set = 1'b1; nxt = ST_IDLE; end
        else if (m_ack_i) begin rx_step = 1'b1; nxt = ST_IDLE; end
      end
      ST_TX_RD: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_sel_o = lane_sel(cur_adr[1:0]);
        m_adr_o = cur_adr;
        if (m_err_i)      begin err_set = 1'b1; nxt = ST_IDLE; end
        else if (m_ack_i) nxt = ST_GAP;
      end
      ST_TX_WR: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_sel_o = 4'b0001;
        m_adr_o = pUartBase;
        m_dat_o = {24'h0, byte_q};
        if (m_err_i)      begin err_set = 1'b1; nxt = ST_IDLE; end
        else if (m_ack_i) begin tx_step = 1'b1; nxt = ST_IDLE; end
      end
      ST_GAP: begin
        // Keep the bus tenure between the read and write phases.
        m_cyc_o = 1'b1;
        nxt     = gap_tx ? ST_TX_WR : ST_RX_WR;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_rx  <= 1'b0;
      gap_tx   <= 1'b0;
      cur_adr  <= '0;
      byte_q   <= '0;
      rx_guard <= '0;
      tx_guard <= '0;
    end else begin
      if (rx_guard != 4'd0) rx_guard <= rx_guard - 4'd1;
      if (tx_guard != 4'd0) tx_guard <= tx_guard - 4'd1;
      case (state)
        ST_IDLE: begin
          if (rx_win) begin
            cur_adr <= rx.adr;
            last_rx <= 1'b1;
            gap_tx  <= 1'b0;
          end else if (tx_win) begin
            cur_adr <= tx.adr;
            last_rx <= 1'b0;
            gap_tx  <= 1'b1;
          end
        end
        ST_RX_RD: if (done_ph) begin
          byte_q   <= m_dat_i[7:0];
          rx_guard <= GUARD;
        end
        ST_TX_RD: if (done_ph) byte_q <= m_dat_i[{cur_adr[1:0], 3'b000} +: 8];
        ST_TX_WR: if (done_ph) tx_guard <= GUARD;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart6551_dmac.sv
// tb_uart6551_dmac: scoreboard bench for uart6551_dmac with a memory/UART bus responder.
// Expected master transactions and slave read data are queued by the stimulus and
// popped by independent monitors whenever the DUT presents a terminated cycle or ack.
module tb_uart6551_dmac;

  localparam logic [31:0] UART  = 32'hFFDC0A00;
  localparam int          GUARD = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } txn_t;

  typedef struct packed {
    logic [2:0]  adr;
    logic [31:0] dat;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cs = 1'b0, cyc = 1'b0, stb = 1'b0, we_s = 1'b0;
  logic [2:0]  adr_s = '0;
  logic [31:0] wdat = '0;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic        m_ack_i = 1'b0, m_err_i = 1'b0;
  logic [31:0] m_dat_i = '0;
  logic        rx_drq = 1'b0, tx_drq = 1'b0;
  logic        irq_o;

  int   n_chk = 0;
  int   n_fail = 0;
  txn_t exp_q[$];
  rd_t  rd_q[$];
  logic [7:0] uart_q[$];
  logic [7:0] mem [logic [31:0]];
  int   txn_idx = 0;
  int   err_idx = -1;
  logic hold_ack = 1'b0;
  logic cyc_seen = 1'b0;

  uart6551_dmac #(.pUartBase(UART), .pGuard(GUARD)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cs_i(cs), .cyc_i(cyc), .stb_i(stb), .ack_o(ack_o),
    .we_i(we_s), .adr_i(adr_s), .dat_i(wdat), .dat_o(dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_dat_i(m_dat_i),
    .rxDRQ_i(rx_drq), .txDRQ_i(tx_drq), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] b = {a[31:2], 2'(i)};
      if (mem.exists(b)) w[8*i +: 8] = mem[b];
    end
    return w;
  endfunction

  // Bus responder: zero-wait-state slave for memory and the UART data register.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (m_cyc_o && m_stb_o && !m_ack_i && !m_err_i && !hold_ack) begin
        txn_idx++;
        if (txn_idx == err_idx) begin
          m_err_i = 1'b1;
        end else begin
          m_ack_i = 1'b1;
          if (!m_we_o) begin
            if (m_adr_o == UART) m_dat_i = (uart_q.size() != 0) ? {24'h0, uart_q.pop_front()} : 32'h0;
            else                 m_dat_i = mem_word(m_adr_o);
          end
        end
      end else begin
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
      end
    end
  end

  // Master-side monitor: every terminated master phase must match the queue head.
  always @(negedge clk) begin
    if (m_cyc_o) cyc_seen = 1'b1;
    if (m_cyc_o && m_stb_o && (m_ack_i || m_err_i)) begin
      txn_t act, exp;
      act = '{we: m_we_o, adr: m_adr_o, sel: m_sel_o, dat: (m_we_o ? m_dat_o : 32'h0)};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL bus_txn: unexpected we=%0b adr=%h sel=%b dat=%h", act.we, act.adr, act.sel, act.dat);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL bus_txn: got we=%0b adr=%h sel=%b dat=%h, expected we=%0b adr=%h sel=%b dat=%h",
                   act.we, act.adr, act.sel, act.dat, exp.we, exp.adr, exp.sel, exp.dat);
        end
      end
    end
  end

  // Slave-side monitor: read data presented with ack_o against the queued value.
  always @(negedge clk) begin
    if (ack_o && !we_s) begin
      rd_t e;
      n_chk++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL reg_read: unexpected ack, dat_o=%h", dat_o);
      end else begin
        e = rd_q.pop_front();
        if (dat_o !== e.dat) begin
          n_fail++;
          $display("FAIL reg_read[%0d]: got %h, expected %h", e.adr, dat_o, e.dat);
        end
      end
    end
  end

  task automatic wb_cycle(input logic w, input logic [2:0] a, input logic [31:0] d);
    int k;
    @(negedge clk);
    cs = 1'b1; cyc = 1'b1; stb = 1'b1; we_s = w; adr_s = a; wdat = d;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack_o) break;
    end
    if (k == 20) chk("slave_ack_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    cs = 1'b0; cyc = 1'b0; stb = 1'b0; we_s = 1'b0;
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [31:0] d);
    wb_cycle(1'b1, a, d);
  endtask

  task automatic wb_rd(input logic [2:0] a, input logic [31:0] e);
    rd_q.push_back('{adr: a, dat: e});
    wb_cycle(1'b0, a, 32'h0);
  endtask

  task automatic exp_rd(input logic [31:0] a, input logic [3:0] s);
    exp_q.push_back('{we: 1'b0, adr: a, sel: s, dat: 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    exp_q.push_back('{we: 1'b1, adr: a, sel: s, dat: d});
  endtask

  task automatic do_reset();
    rx_drq = 1'b0; tx_drq = 1'b0; hold_ack = 1'b0;
    exp_q.delete(); uart_q.delete();
    txn_idx = 0; err_idx = -1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_cyc_o) break;
    end
    chk(name, 32'(k < 2000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int lows, k;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_ctl_outs", {27'h0, ack_o, m_cyc_o, m_stb_o, m_we_o, irq_o}, 32'h0);
    chk("rst_m_adr", m_adr_o, 32'h0);
    chk("rst_m_dat_sel", m_dat_o | {28'h0, m_sel_o}, 32'h0);
    chk("rst_dat_o", dat_o, 32'h0);
    for (int r = 0; r < 8; r++) wb_rd(3'(r), 32'h0);

    // RX: three bytes from the UART into 0x1000..0x1002
    do_reset();
    uart_q.push_back(8'h41); uart_q.push_back(8'h42); uart_q.push_back(8'h43);
    exp_rd(UART, 4'b0001); exp_wr(32'h1000, 4'b0001, 32'h41414141);
    exp_rd(UART, 4'b0001); exp_wr(32'h1001, 4'b0010, 32'h42424242);
    exp_rd(UART, 4'b0001); exp_wr(32'h1002, 4'b0100, 32'h43434343);
    wb_wr(3'd2, 32'h1000);
    wb_wr(3'd3, 32'd3);
    rx_drq = 1'b1;
    wb_wr(3'd4, 32'h0000000A);
    wait_idle("rx_done_wait");
    wb_rd(3'd4, 32'h00000208);
    wb_rd(3'd3, 32'h0);
    wb_rd(3'd2, 32'h1003);
    chk("rx_irq", {31'h0, irq_o}, 32'h1);

    // TX: 0x55 from lane 3 of 0x2000, then 0xAA at 0x2004; guard gap with DRQ held high
    do_reset();
    mem[32'h2000] = 8'h11; mem[32'h2001] = 8'h22; mem[32'h2002] = 8'h33;
    mem[32'h2003] = 8'h55; mem[32'h2004] = 8'hAA; mem[32'h2005] = 8'hEE;
    exp_rd(32'h2003, 4'b1000); exp_wr(UART, 4'b0001, 32'h00000055);
    exp_rd(32'h2004, 4'b0001); exp_wr(UART, 4'b0001, 32'h000000AA);
    wb_wr(3'd0, 32'h2003);
    wb_wr(3'd1, 32'd2);
    tx_drq = 1'b1;
    wb_wr(3'd4, 32'h1);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_stb_o && m_we_o && m_ack_i && m_adr_o == UART) break;
    end
    chk("tx_wr_seen", 32'(k < 200), 32'd1);
    lows = 0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (m_cyc_o) break;
      lows++;
    end
    chk("tx_guard_gap", 32'(lows), 32'(GUARD + 1));
    wait_idle("tx_done_wait");
    wb_rd(3'd4, 32'h00000100);
    wb_rd(3'd0, 32'h2005);
    wb_rd(3'd1, 32'h0);
    chk("tx_irq_masked", {31'h0, irq_o}, 32'h0);

    // Both channels busy: bursts alternate, RX first after reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem[32'h4000 + 32'(i)] = 8'hA0 + 8'(i);
      uart_q.push_back(8'h10 + 8'(i));
    end
    exp_rd(UART, 4'b0001); exp_wr(32'h3000, 4'b0001, 32'h10101010);
    exp_rd(32'h4000, 4'b0001); exp_wr(UART, 4'b0001, 32'h000000A0);
    exp_rd(UART, 4'b0001); exp_wr(32'h3001, 4'b0010, 32'h11111111);
    exp_rd(32'h4001, 4'b0010); exp_wr(UART, 4'b0001, 32'h000000A1);
    exp_rd(UART, 4'b0001); exp_wr(32'h3002, 4'b0100, 32'h12121212);
    exp_rd(32'h4002, 4'b0100); exp_wr(UART, 4'b0001, 32'h000000A2);
    exp_rd(UART, 4'b0001); exp_wr(32'h3003, 4'b1000, 32'h13131313);
    exp_rd(32'h4003, 4'b1000); exp_wr(UART, 4'b0001, 32'h000000A3);
    wb_wr(3'd0, 32'h4000); wb_wr(3'd1, 32'd4);
    wb_wr(3'd2, 32'h3000); wb_wr(3'd3, 32'd4);
    rx_drq = 1'b1; tx_drq = 1'b1;
    wb_wr(3'd4, 32'h3);
    wait_idle("alt_done_wait");
    wb_rd(3'd4, 32'h00000300);
    wb_rd(3'd2, 32'h3004);
    wb_rd(3'd0, 32'h4004);

    // Bus error on the second RX memory write
    do_reset();
    err_idx = 4;
    uart_q.push_back(8'h61); uart_q.push_back(8'h62);
    exp_rd(UART, 4'b0001); exp_wr(32'h1000, 4'b0001, 32'h61616161);
    exp_rd(UART, 4'b0001); exp_wr(32'h1001, 4'b0010, 32'h62626262);
    wb_wr(3'd0, 32'h2000); wb_wr(3'd1, 32'd5);
    wb_wr(3'd2, 32'h1000); wb_wr(3'd3, 32'd3);
    rx_drq = 1'b1;
    wb_wr(3'd4, 32'h3);
    wait_idle("err_wait");
    wb_rd(3'd4, 32'h00000400);
    wb_rd(3'd3, 32'd2);
    wb_rd(3'd2, 32'h1001);
    wb_rd(3'd1, 32'd5);
    chk("err_irq", {31'h0, irq_o}, 32'h1);

    // Enable with TXCNT=0: done without any bus cycle, then W1C
    do_reset();
    tx_drq = 1'b1;
    cyc_seen = 1'b0;
    wb_wr(3'd4, 32'h5);
    repeat (5) @(negedge clk);
    chk("zero_cnt_no_cyc", {31'h0, cyc_seen}, 32'h0);
    wb_rd(3'd4, 32'h00000104);
    chk("zero_cnt_irq", {31'h0, irq_o}, 32'h1);
    wb_wr(3'd4, 32'h00000100);
    wb_rd(3'd4, 32'h0);
    repeat (2) @(negedge clk);
    chk("w1c_irq_clear", {31'h0, irq_o}, 32'h0);

    // Reset in the middle of a bus tenure
    do_reset();
    hold_ack = 1'b1;
    uart_q.push_back(8'h77);
    wb_wr(3'd2, 32'h5000); wb_wr(3'd3, 32'd1);
    rx_drq = 1'b1;
    wb_wr(3'd4, 32'hA);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (m_stb_o) break;
    end
    chk("midrst_stb_seen", 32'(k < 50), 32'd1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ctl_outs", {27'h0, ack_o, m_cyc_o, m_stb_o, m_we_o, irq_o}, 32'h0);
    chk("midrst_m_adr", m_adr_o, 32'h0);
    chk("midrst_m_sel", {28'h0, m_sel_o}, 32'h0);
    rst_i = 1'b0;
    hold_ack = 1'b0;
    rx_drq = 1'b0;
    wb_rd(3'd4, 32'h0);
    wb_rd(3'd3, 32'h0);

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

endmodule
